// File: rtl/cmd_ctrl.sv
// cmd_ctrl: command sequencer behind the UART string recogniser.
// Runs the RUN/IDLE control FSM and the elapsed-cycle counter, and streams
// a 4-byte ASCII reply per command to the transmitter (valid/ready).
//
// Ports:
//   clk, rst                   clock, async active-high reset
//   is_start, is_stop, other   one-cycle command pulses (stop > start > other)
//   tx_ready / tx_valid        byte handshake towards uart_tx
//   tx_data                    reply byte, held while tx_valid & !tx_ready
//   run                        1 while in RUN
//   elapsed                    cycles spent in RUN since the last accepted start
//   busy                       reply in progress
//   drop_cnt                   commands dropped while busy (saturates at 255)
//
// Optional feature: define CMD_CTRL_TIMEOUT_EN to auto-stop after TIMEOUT
// cycles of RUN with a "TO\r\n" reply.

module cmd_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 100000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             is_start,
    input  logic             is_stop,
    input  logic             other,
    input  logic             tx_ready,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    output logic             run,
    output logic [CNT_W-1:0] elapsed,
    output logic             busy,
    output logic [7:0]       drop_cnt
);

    localparam logic [31:0] MSG_GO = 32'h474F_0D0A;
    localparam logic [31:0] MSG_ER = 32'h4552_0D0A;
    localparam logic [31:0] MSG_OK = 32'h4F4B_0D0A;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("cmd_ctrl: TIMEOUT must be at least 2");
    end

    typedef enum logic {IDLE, RUN} ctrl_t;
    typedef enum logic {R_IDLE, R_SEND} rstate_t;

    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] elapsed_q, elapsed_d;
    rstate_t          rstate_q, rstate_d;
    logic [1:0]       idx_q, idx_d;
    logic [31:0]      msg_q, msg_d;
    logic [7:0]       drop_q, drop_d;

    logic        in_run;
    logic        to_hit;
    logic        ev_any;
    logic [31:0] ev_msg;

    assign in_run = (ctrl_q == RUN);

`ifdef CMD_CTRL_TIMEOUT_EN
    localparam logic [31:0] MSG_TO = 32'h544F_0D0A;
    localparam int          TO_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Counts RUN cycles; zero on the cycle RUN is entered.
    always_comb begin
        to_cnt_d = in_run ? to_cnt_q + TO_W'(1) : '0;
    end

    assign to_hit = in_run && (to_cnt_q == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    // Control FSM: exactly one event per cycle, stop > timeout > start > other.
    always_comb begin
        ctrl_d    = ctrl_q;
        elapsed_d = in_run ? elapsed_q + CNT_W'(1) : elapsed_q;
        ev_any    = is_stop | to_hit | is_start | other;
        ev_msg    = MSG_ER;
        if (is_stop) begin
            ctrl_d = IDLE;
            if (in_run) begin
                ev_msg = MSG_OK;
            end
`ifdef CMD_CTRL_TIMEOUT_EN
        end else if (to_hit) begin
            ctrl_d = IDLE;
            ev_msg = MSG_TO;
`endif
        end else if (is_start && !in_run) begin
            ctrl_d    = RUN;
            elapsed_d = '0;
            ev_msg    = MSG_GO;
        end
    end

    // Reply FSM: msg_q shifts left so tx_data is always the top byte.
    always_comb begin
        rstate_d = rstate_q;
        idx_d    = idx_q;
        msg_d    = msg_q;
        drop_d   = drop_q;
        if (rstate_q == R_SEND && tx_ready) begin
            msg_d = {msg_q[23:0], 8'h00};
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
                rstate_d = R_IDLE;
            end
        end
        // Busy includes the cycle of the final handshake.
        if (ev_any) begin
            if (rstate_q == R_IDLE) begin
                rstate_d = R_SEND;
                idx_d    = 2'd0;
                msg_d    = ev_msg;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q    <= IDLE;
            elapsed_q <= '0;
            rstate_q  <= R_IDLE;
            idx_q     <= 2'd0;
            msg_q     <= '0;
            drop_q    <= 8'd0;
        end else begin
            ctrl_q    <= ctrl_d;
            elapsed_q <= elapsed_d;
            rstate_q  <= rstate_d;
            idx_q     <= idx_d;
            msg_q     <= msg_d;
            drop_q    <= drop_d;
        end
    end

    assign run      = in_run;
    assign elapsed  = elapsed_q;
    assign tx_valid = (rstate_q == R_SEND);
    assign busy     = (rstate_q == R_SEND);
    assign tx_data  = msg_q[31:24];
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_cmd_ctrl.sv
// tb_cmd_ctrl: directed + randomized bench for cmd_ctrl against a
// queue-based reply model and plain arithmetic for run/elapsed/drops.

module tb_cmd_ctrl;

    localparam int TO = 20;

    localparam logic [31:0] S_GO = 32'h474F_0D0A;
    localparam logic [31:0] S_ER = 32'h4552_0D0A;
    localparam logic [31:0] S_OK = 32'h4F4B_0D0A;
    localparam logic [31:0] S_TO = 32'h544F_0D0A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        is_start = 1'b0;
    logic        is_stop = 1'b0;
    logic        other = 1'b0;
    logic        tx_ready = 1'b0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        run;
    logic [31:0] elapsed;
    logic        busy;
    logic [7:0]  drop_cnt;

    cmd_ctrl #(
        .CNT_W   (32),
        .TIMEOUT (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .is_start (is_start),
        .is_stop  (is_stop),
        .other    (other),
        .tx_ready (tx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .run      (run),
        .elapsed  (elapsed),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit          m_run;
    logic [31:0] m_el;
    int          m_to;
    bit          m_busy;
    logic [7:0]  m_q[$];
    int          m_drop;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_el   = '0;
        m_to   = 0;
        m_busy = 1'b0;
        m_q.delete();
        m_drop = 0;
    endtask

    task automatic model_edge(bit s, bit p, bit o, bit r);
        bit          ev;
        bit          nrun;
        bit          clr;
        bit          was_busy;
        logic [31:0] msg;
        ev   = 1'b0;
        nrun = m_run;
        clr  = 1'b0;
        msg  = S_ER;
        if (p) begin
            ev   = 1'b1;
            msg  = m_run ? S_OK : S_ER;
            nrun = 1'b0;
`ifdef CMD_CTRL_TIMEOUT_EN
        end else if (m_run && m_to == TO - 1) begin
            ev   = 1'b1;
            msg  = S_TO;
            nrun = 1'b0;
`endif
        end else if (s) begin
            ev = 1'b1;
            if (!m_run) begin
                msg  = S_GO;
                nrun = 1'b1;
                clr  = 1'b1;
            end
        end else if (o) begin
            ev = 1'b1;
        end
        was_busy = m_busy;
        if (m_busy && r) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_busy = 1'b0;
        end
        if (ev) begin
            if (was_busy) begin
                if (m_drop < 255) m_drop++;
            end else begin
                for (int i = 3; i >= 0; i--) m_q.push_back(msg[i*8 +: 8]);
                m_busy = 1'b1;
            end
        end
        if (clr) m_el = '0;
        else if (m_run) m_el = m_el + 32'd1;
        m_to  = (m_run && nrun) ? m_to + 1 : 0;
        m_run = nrun;
    endtask

    task automatic compare_all();
        chk("run", {31'd0, run}, {31'd0, m_run});
        chk("elapsed", elapsed, m_el);
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("tx_valid", {31'd0, tx_valid}, {31'd0, m_busy});
        if (m_busy && m_q.size() > 0) chk("tx_data", {24'd0, tx_data}, {24'd0, m_q[0]});
        chk("drop_cnt", {24'd0, drop_cnt}, m_drop);
    endtask

    task automatic step(bit s, bit p, bit o, bit r);
        is_start = s;
        is_stop  = p;
        other    = o;
        tx_ready = r;
        @(posedge clk);
        model_edge(s, p, o, r);
        #1;
        is_start = 1'b0;
        is_stop  = 1'b0;
        other    = 1'b0;
        compare_all();
    endtask

    task automatic idle(int n, bit r);
        for (int i = 0; i < n; i++) step(0, 0, 0, r);
    endtask

    initial begin
        int r;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        rst = 1'b0;

        // Start, count, GO reply
        step(1, 0, 0, 1);
        idle(12, 1);
        // Stop: elapsed frozen, OK reply
        step(0, 1, 0, 1);
        chk("elapsed_frozen", elapsed, 32'd13);
        idle(6, 1);

        // Backpressure in the middle of a GO reply
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        idle(5, 0);
        idle(4, 1);
        step(0, 1, 0, 1);
        idle(5, 1);

        // Drop while busy
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        chk("drop_one", {24'd0, drop_cnt}, 32'd1);
        chk("run_after_drop", {31'd0, run}, 32'd1);
        for (int i = 0; i < 300; i++) step(0, 0, 1, 0);
        chk("drop_sat", {24'd0, drop_cnt}, 32'd255);
        idle(6, 1);
        step(0, 1, 0, 1);
        idle(5, 1);

        // Simultaneous start & stop while IDLE
        step(1, 1, 0, 1);
        chk("sim_run", {31'd0, run}, 32'd0);
        idle(5, 1);

        // Run long enough for a timeout when enabled
        step(1, 0, 0, 1);
        idle(TO + 8, 1);
        step(0, 1, 0, 1);
        idle(5, 1);

        // Reset in the middle of a reply
        step(1, 0, 0, 0);
        idle(2, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_run", {31'd0, run}, 32'd0);
        chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(2, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 11);
            step(r == 0 || r == 3 || r == 4,
                 r == 1 || r == 3 || r == 4,
                 r == 2 || r == 4 || r == 5,
                 $urandom_range(0, 3) != 0);
        end
        idle(8, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmd_ctrl.md
Name: cmd_ctrl

Overview:
Command sequencer behind the UART string recogniser. Consumes the single-cycle is_start / is_stop / other pulses and runs a RUN/IDLE control state machine. That state machine gates an elapsed-cycle counter. For every command, cmd_ctrl streams a 4-byte ASCII reply to the UART transmitter over a valid/ready handshake. It sits between str_rec and the uart_tx / display datapath.

Parameters:
CNT_W, 32, width of elapsed-cycle counter
TIMEOUT, 100000000, cycles of RUN before auto-stop (used only with CMD_CTRL_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
is_start  in  1  one-cycle pulse: "start" recognised
is_stop  in  1  one-cycle pulse: "stop" recognised
other  in  1  one-cycle pulse: unrecognised string
tx_ready  in  1  transmitter can accept a byte
tx_valid  out  1  tx_data holds a valid reply byte
tx_data  out  8  reply byte
run  out  1  1 = RUN state
elapsed  out  CNT_W  cycles spent in RUN since last accepted start
busy  out  1  reply in progress
drop_cnt  out  8  commands dropped while busy; saturates at 255

Behaviour:
- Reset (async, immediate) forces all outputs to 0 and both FSMs to their initial states (IDLE, R_IDLE).
- Input priority when pulses coincide: is_stop > is_start > other. Only one event is taken per cycle; the rest are ignored and not counted as drops.
- Control FSM, IDLE:
  - is_start: go to RUN on the next edge; clear elapsed to 0; reply "GO\r\n" (0x47 0x4F 0x0D 0x0A).
  - is_stop or other: stay in IDLE; reply "ER\r\n" (0x45 0x52 0x0D 0x0A).
- Control FSM, RUN:
  - is_stop: go to IDLE; freeze elapsed; reply "OK\r\n" (0x4F 0x4B 0x0D 0x0A).
  - is_start: stay in RUN; elapsed is not cleared; reply "ER\r\n".
  - other: reply "ER\r\n"; no state change.
- run is registered. It changes on the edge after the accepting pulse.
- elapsed:
  - Increments by 1 each cycle while run=1 and wraps modulo 2^CNT_W.
  - Holds while run=0.
  - Cleared only on an accepted start or by reset.
- State changes happen even while a reply is busy. Only the reply is subject to dropping.
- Reply FSM:
  - States: R_IDLE, R_SEND with byte index 0..3.
  - An event in R_IDLE latches the 4-byte string. tx_valid=1 and busy=1 from the next cycle, with byte 0 on tx_data.
  - tx_data is held stable while tx_valid=1 and tx_ready=0.
  - On tx_valid & tx_ready the index advances. If the byte was index 3, return to R_IDLE with tx_valid=0 and busy=0 on the next cycle.
  - There are no gaps between bytes when tx_ready stays high, so a 4-byte reply takes exactly 4 cycles.
- Events arriving while busy=1, including in the cycle the last byte handshakes:
  - No reply is produced.
  - drop_cnt increments by 1, saturating at 255.
  - The control-state effect still applies.
- Reset during a reply aborts it immediately: tx_valid=0, and no partial byte is held over.

Optional Feature:
Macro CMD_CTRL_TIMEOUT_EN.
- Defined: a timeout counter clears on entry to RUN and counts while in RUN. When it reaches TIMEOUT-1, the FSM returns to IDLE on the next edge and replies "TO\r\n" (0x54 0x4F 0x0D 0x0A), subject to the same busy/drop rule. A stop pulse in the same cycle as the timeout takes priority and replies "OK".
- Not defined: the counter and logic are absent and RUN persists until a stop.

Test Plan:
- Reset, then pulse is_start with tx_ready=1. Expect:
  - run=1 next cycle, elapsed counting 0,1,2,…
  - tx_data 0x47,0x4F,0x0D,0x0A on 4 consecutive cycles, busy low afterwards.
- After ≥10 cycles of RUN, pulse is_stop. Expect run=0, elapsed frozen at the cycles spent in RUN, reply 0x4F,0x4B,0x0D,0x0A.
- Backpressure: tx_ready=0 for 5 cycles during a reply. Expect tx_data held at the current byte and tx_valid held at 1; the sequence resumes unchanged when tx_ready=1.
- Drop: pulse other 2 cycles after is_start with tx_ready=0. Expect only the "GO" reply, drop_cnt=1, run=1. Repeat 300 such drops: drop_cnt=255.
- Simultaneous is_start & is_stop while IDLE. Expect a stop response: run stays 0, reply "ER".
- With CMD_CTRL_TIMEOUT_EN and TIMEOUT=20, start and wait. Expect run to drop 20 cycles after entering RUN and reply 0x54,0x4F,0x0D,0x0A. Pulse reset mid-reply: tx_valid=0 immediately.
